// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction-memory address/data, redirect request and
// the decode-side valid/ready queue head.
interface ifetch_if #(
   parameter int QDEPTH = 4
);
   logic [31:0]              imem_addr;
   logic [31:0]              imem_instr;
   logic                     redirect_valid;
   logic [31:0]              redirect_pc;
   logic                     dec_ready;
   logic                     dec_valid;
   logic [31:0]              dec_instr;
   logic [31:0]              dec_pc;
   logic [31:0]              dec_pc_plus4;
   logic [$clog2(QDEPTH):0]  q_count;
   logic                     fetch_misaligned;

   modport master (
      output imem_addr,
      input  imem_instr,
      input  redirect_valid,
      input  redirect_pc,
      input  dec_ready,
      output dec_valid,
      output dec_instr,
      output dec_pc,
      output dec_pc_plus4,
      output q_count,
      output fetch_misaligned
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      output redirect_valid,
      output redirect_pc,
      output dec_ready,
      input  dec_valid,
      input  dec_instr,
      input  dec_pc,
      input  dec_pc_plus4,
      input  q_count,
      input  fetch_misaligned
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, combinational imem lookup and a
// small {pc, instr} queue feeding decode, with flushing redirects.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 4
) (
   input  logic      clk,
   input  logic      rst,
   ifetch_if.master  bus
);
   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH) + 1;

   logic [31:0]   pc_q, pc_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [31:0]   slot_pc    [QDEPTH];
   logic [31:0]   slot_instr [QDEPTH];

   logic          misaligned;
   logic          head_valid;
   logic          dec_fire;
   logic          fetch_fire;

   // The PC itself carries the misaligned state: only a redirect can make it
   // unaligned, and fetch never advances it while it is.
   assign misaligned = |pc_q[1:0];
   assign head_valid = (count_q != '0);
   assign dec_fire   = head_valid & bus.dec_ready;
   assign fetch_fire = ~bus.redirect_valid & ~misaligned &
                       ((count_q < CW'(QDEPTH)) | dec_fire);

   genvar gi;
   generate
      for (gi = 0; gi < QDEPTH; gi++) begin : g_slot
         logic [31:0] pc_slot_q;
         logic [31:0] instr_slot_q;

         always_ff @(posedge clk) begin
            if (fetch_fire && (wr_ptr_q == PW'(gi))) begin
               pc_slot_q    <= pc_q;
               instr_slot_q <= bus.imem_instr;
            end
         end

         assign slot_pc[gi]    = pc_slot_q;
         assign slot_instr[gi] = instr_slot_q;
      end
   endgenerate

   always_comb begin
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.redirect_valid) begin
         pc_d     = bus.redirect_pc;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (fetch_fire) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (dec_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({fetch_fire, dec_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign bus.imem_addr        = pc_q;
   assign bus.fetch_misaligned = misaligned;
   assign bus.q_count          = count_q;
   assign bus.dec_valid        = head_valid;
   // Head fields read as zero whenever the queue is empty.
   assign bus.dec_pc           = head_valid ? slot_pc[rd_ptr_q]    : 32'h0;
   assign bus.dec_instr        = head_valid ? slot_instr[rd_ptr_q] : 32'h0;
   assign bus.dec_pc_plus4     = head_valid ? (slot_pc[rd_ptr_q] + 32'd4) : 32'h0;
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit, checked every cycle against a queue-based
// reference model of the fetch stage.
module tb_ifetch_unit;
   localparam int          QD  = 4;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ifetch_if #(.QDEPTH(QD)) bus ();

   ifetch_unit #(.RESET_PC(32'h0), .QDEPTH(QD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_instr = bus.imem_addr ^ KEY;

   int vectors    = 0;
   int miscompares = 0;

   logic [31:0] m_pc;
   logic [63:0] m_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic        ev;
      logic [31:0] epc;
      logic [31:0] ein;
      ev  = (m_q.size() > 0);
      epc = ev ? m_q[0][63:32] : 32'h0;
      ein = ev ? m_q[0][31:0]  : 32'h0;
      check_val("dec_valid",    32'(bus.dec_valid), 32'(ev));
      check_val("dec_pc",       bus.dec_pc, epc);
      check_val("dec_instr",    bus.dec_instr, ein);
      check_val("dec_pc_plus4", bus.dec_pc_plus4, ev ? epc + 32'd4 : 32'h0);
      check_val("q_count",      32'(bus.q_count), 32'(m_q.size()));
      check_val("imem_addr",    bus.imem_addr, m_pc);
      check_val("misaligned",   32'(bus.fetch_misaligned), 32'(m_pc[1:0] != 2'b00));
   endtask

   // Check the current state, apply inputs for one clock, advance the model.
   task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
      logic fire;
      logic ff;
      check_outputs();
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.dec_ready      = rdy;
      fire = (m_q.size() > 0) && rdy;
      if (rv) begin
         m_q.delete();
         m_pc = rpc;
      end else begin
         ff = (m_pc[1:0] == 2'b00) && ((m_q.size() < QD) || fire);
         if (fire) void'(m_q.pop_front());
         if (ff) begin
            m_q.push_back({m_pc, m_pc ^ KEY});
            m_pc = m_pc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] t;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.dec_ready      = 1'b0;
      m_pc = 32'h0;
      m_q.delete();

      @(negedge clk);
      check_outputs();
      @(negedge clk);
      rst = 1'b0;

      // Streaming, then back-pressure to full, then drain.
      for (int i = 0; i < 6; i++)  cycle(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++)  cycle(1'b0, 32'h0, 1'b1);

      // Flush with entries queued.
      for (int i = 0; i < 3; i++)  cycle(1'b0, 32'h0, 1'b0);
      cycle(1'b1, 32'h100, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1);

      // Misaligned target halts fetch; aligned redirect resumes.
      cycle(1'b1, 32'h102, 1'b1);
      for (int i = 0; i < 4; i++)  cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b1, 32'h200, 1'b0);
      for (int i = 0; i < 3; i++)  cycle(1'b0, 32'h0, 1'b1);

      // PC wrap at the top of the address space.
      cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
      for (int i = 0; i < 4; i++)  cycle(1'b0, 32'h0, 1'b1);

      // Redirect together with dec_ready on an empty queue.
      cycle(1'b1, 32'h300, 1'b1);
      cycle(1'b1, 32'h400, 1'b1);
      for (int i = 0; i < 3; i++)  cycle(1'b0, 32'h0, 1'b1);

      // Async reset from a full queue, between edges.
      for (int i = 0; i < 6; i++)  cycle(1'b0, 32'h0, 1'b0);
      #2 rst = 1'b1;
      #1;
      m_q.delete();
      m_pc = 32'h0;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic rv;
         logic rdy;
         rv  = ($urandom_range(0, 9) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 3))
            0:       t = 32'hFFFF_FFF0 | {28'h0, 4'($urandom_range(0, 15))};
            1:       t = $urandom;
            default: t = $urandom & 32'hFFFF_FFFC;
         endcase
         cycle(rv, t, rdy);
      end

      // Async reset while misaligned.
      cycle(1'b1, 32'h0000_0501, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      #2 rst = 1'b1;
      #1;
      m_q.delete();
      m_pc = 32'h0;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++)  cycle(1'b0, 32'h0, 1'b1);
      check_outputs();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
